// File: rtl/shake_sample_extractor_pkg.sv
// Shared definitions for the SHAKE128 sample extractor: the default block and
// word sizes and the run-control state encoding.
package shake_sample_extractor_pkg;

  // Bits per SHAKE128 squeeze block (rate of SHAKE128).
  localparam int SHAKE128_OUTPUT_SIZE = 1344;

  // Default maximum sample width.
  localparam int WORD_SIZE = 16;

  // Run-control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Map the requested sample width to the effective one (0 selects the
  // full word width).
  function automatic int effective_nbits(input int requested, input int word_width);
    return (requested == 0) ? word_width : requested;
  endfunction

endpackage

// File: rtl/shake_sample_extractor_variable_shift.sv
// Logarithmic left shifter. One instance serves both the block-merge path and
// the sample-pop path of the extractor, so it carries the full buffer width.
module variable_shift #(
  parameter int WIDTH = 8,
  localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SH_W-1:0]  amount,
  output logic [WIDTH-1:0] result
);

  // stage[s] holds data shifted by the low s bits of amount.
  logic [WIDTH-1:0] stage [SH_W+1];

  assign stage[0] = data;

  for (genvar s = 0; s < SH_W; s++) begin : g_stage
    // Each stage shifts by a power of two when its amount bit is set.
    assign stage[s+1] = amount[s] ? (stage[s] << (1 << s)) : stage[s];
  end

  assign result = stage[SH_W];

endmodule

// File: rtl/shake_sample_extractor.sv
// Extracts fixed-width samples from a stream of SHAKE128 output blocks.
// Blocks are appended MSB-first into a left-aligned bit buffer; samples of
// nbits are popped from the top of that buffer one per cycle while enough
// bits are held, and a new block is requested whenever fewer than nbits
// remain. A run emits num_words samples and then discards any leftovers.
module shake_sample_extractor
  import shake_sample_extractor_pkg::*;
#(
  parameter int IN_WIDTH  = SHAKE128_OUTPUT_SIZE,
  parameter int OUT_WIDTH = WORD_SIZE
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic [$clog2(OUT_WIDTH+1)-1:0] i_nbits,
  input  logic [15:0]                    i_num_words,
  input  logic [IN_WIDTH-1:0]            i_block,
  input  logic                           i_block_valid,
  output logic                           o_block_ready,
  output logic [OUT_WIDTH-1:0]           o_word,
  output logic                           o_word_valid,
  input  logic                           i_word_ready,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int BUF_WIDTH = IN_WIDTH + OUT_WIDTH;
  localparam int NB_W      = $clog2(OUT_WIDTH + 1);
  localparam int FILL_W    = $clog2(BUF_WIDTH + 1);
  localparam int SH_W      = $clog2(BUF_WIDTH);
  localparam int FILL_MAX  = OUT_WIDTH - 1 + IN_WIDTH;

  state_t               state;
  state_t               state_next;
  logic [BUF_WIDTH-1:0] bit_buf;
  logic [FILL_W-1:0]    fill;
  logic [15:0]          words_left;
  logic [NB_W-1:0]      nbits;

  logic                 run;
  logic                 block_xfer;
  logic                 word_xfer;
  logic                 done_entry;

  logic [BUF_WIDTH-1:0] shift_in;
  logic [SH_W-1:0]      shift_amt;
  logic [BUF_WIDTH-1:0] shift_out;

  logic [FILL_W-1:0]    nbits_ext;
  logic [OUT_WIDTH-1:0] word_top;
  logic [NB_W-1:0]      rj_amt;

  assign nbits_ext = FILL_W'(nbits);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next    = state;
    run           = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    o_block_ready = 1'b0;
    o_word_valid  = 1'b0;
    block_xfer    = 1'b0;
    word_xfer     = 1'b0;
    done_entry    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (i_start) state_next = ST_RUN;
      end
      ST_RUN: begin
        run    = 1'b1;
        o_busy = 1'b1;
        // A block is requested only while samples are still owed, so an
        // empty run never asks for data.
        o_block_ready = (words_left != 16'd0) && (fill < nbits_ext);
        o_word_valid  = (words_left != 16'd0) && (fill >= nbits_ext);
        block_xfer    = o_block_ready && i_block_valid;
        word_xfer     = o_word_valid && i_word_ready;
        if ((words_left == 16'd0) || (word_xfer && words_left == 16'd1)) begin
          state_next = ST_DONE;
          done_entry = 1'b1;
        end
      end
      ST_DONE: begin
        o_busy     = 1'b1;
        o_done     = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Shared shifter operand/amount select: merge places the new block just
  // below the valid bits, pop discards the sample at the top. The two
  // transfers are mutually exclusive because ready and valid never coincide.
  always_comb begin
    shift_in  = bit_buf;
    shift_amt = SH_W'(nbits);
    if (block_xfer) begin
      shift_in  = {{OUT_WIDTH{1'b0}}, i_block};
      shift_amt = SH_W'(FILL_W'(OUT_WIDTH) - fill);
    end
  end

  variable_shift #(
    .WIDTH (BUF_WIDTH)
  ) u_shift (
    .data   (shift_in),
    .amount (shift_amt),
    .result (shift_out)
  );

  // Buffer, fill level, remaining-sample counter and latched run settings.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: the bit buffer is an ordinary register, not a RAM, so it is
    // reset like everything else; o_word is derived from it and must read
    // zero straight out of reset.
    if (!i_rst_n) begin
      bit_buf    <= '0;
      fill       <= '0;
      words_left <= '0;
      nbits      <= NB_W'(OUT_WIDTH);
    end else begin
      if (state == ST_IDLE && i_start) begin
        nbits      <= NB_W'(effective_nbits(int'(i_nbits), OUT_WIDTH));
        words_left <= i_num_words;
      end

      if (done_entry) begin
        bit_buf    <= '0;
        fill       <= '0;
        words_left <= '0;
      end else if (block_xfer) begin
        bit_buf <= bit_buf | shift_out;
        fill    <= fill + FILL_W'(IN_WIDTH);
      end else if (word_xfer) begin
        bit_buf    <= shift_out;
        fill       <= fill - nbits_ext;
        words_left <= words_left - 16'd1;
      end
    end
  end

  // Right-justify the top OUT_WIDTH buffer bits down to the sample width.
  assign word_top = bit_buf[BUF_WIDTH-1 -: OUT_WIDTH];
  assign rj_amt   = NB_W'(OUT_WIDTH) - nbits;

  // Sample output, forced to zero outside RUN.
  always_comb begin
    o_word = '0;
    if (run) o_word = word_top >> rj_amt;
  end

  // The buffer can never legally hold more than one block plus a partial
  // sample.
  assert property (@(posedge i_clk) disable iff (!i_rst_n) fill <= FILL_W'(FILL_MAX));

endmodule

// File: tb/tb_shake_sample_extractor.sv
// Randomised bench for shake_sample_extractor. Expected samples come from a
// bit-stream model: blocks are flattened MSB-first into a bit queue and
// sample i is bits [i*n, i*n+n) of that stream.
module tb_shake_sample_extractor;

  localparam int IN_W  = 1344;
  localparam int OUT_W = 16;
  localparam int NB_W  = $clog2(OUT_W + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [NB_W-1:0]  i_nbits = '0;
  logic [15:0]      i_num_words = '0;
  logic [IN_W-1:0]  i_block = '0;
  logic             i_block_valid = 1'b0;
  logic             o_block_ready;
  logic [OUT_W-1:0] o_word;
  logic             o_word_valid;
  logic             i_word_ready = 1'b0;
  logic             o_busy;
  logic             o_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shake_sample_extractor #(
    .IN_WIDTH  (IN_W),
    .OUT_WIDTH (OUT_W)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (i_start),
    .i_nbits       (i_nbits),
    .i_num_words   (i_num_words),
    .i_block       (i_block),
    .i_block_valid (i_block_valid),
    .o_block_ready (o_block_ready),
    .o_word        (o_word),
    .o_word_valid  (o_word_valid),
    .i_word_ready  (i_word_ready),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {43'd0, o_block_ready, o_word_valid, o_busy, o_done, o_word};
  endfunction

  function automatic logic [IN_W-1:0] make_block(input bit incrementing);
    logic [IN_W-1:0] blk;
    blk = '0;
    if (incrementing) begin
      for (int k = 0; k < IN_W / 8; k++) blk[IN_W-1-8*k -: 8] = 8'(k);
    end else begin
      for (int k = 0; k < IN_W / 32; k++) blk[32*k +: 32] = $urandom();
    end
    return blk;
  endfunction

  // One run: n_req is the raw i_nbits value, stall_pct the percentage of
  // cycles each handshake input is held low, reset_at the sample index at
  // which to pulse reset (-1: never), restart_at the sample index at which
  // to pulse i_start with other settings (-1: never).
  task automatic run_case(input int n_req, input int num, input bit inc_blocks,
                          input int stall_pct, input int reset_at, input int restart_at);
    int n, nblk, got, blk_idx, req_checked;
    bit last_xfer, done_seen, holding, restarted;
    logic [OUT_W-1:0] held, w;
    logic [IN_W-1:0] blocks[$];
    bit stream[$];
    logic [OUT_W-1:0] exp_words[$];

    n    = (n_req == 0) ? OUT_W : n_req;
    nblk = (num * n + IN_W - 1) / IN_W;
    for (int b = 0; b < nblk; b++) begin
      blocks.push_back(make_block(inc_blocks));
      for (int k = IN_W - 1; k >= 0; k--) stream.push_back(blocks[b][k]);
    end
    for (int i = 0; i < num; i++) begin
      w = '0;
      for (int j = 0; j < n; j++) w = (w << 1) | OUT_W'(stream[i*n+j]);
      exp_words.push_back(w);
    end

    @(posedge clk); #1;
    i_nbits     = NB_W'(n_req);
    i_num_words = 16'(num);
    i_start     = 1'b1;
    @(posedge clk); #1;
    i_start     = 1'b0;
    i_nbits     = NB_W'($urandom_range(OUT_W));
    i_num_words = 16'($urandom());
    check("busy_on_start", o_busy, 1);

    got = 0; blk_idx = 0; req_checked = -1;
    last_xfer = 0; done_seen = 0; holding = 0; restarted = 0; held = '0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      i_start = 1'b0;
      if (last_xfer) begin
        check("done_after_last", o_done, 1);
        done_seen = 1;
        break;
      end
      if (o_done) begin
        check("early_done_words", got, num);
        done_seen = 1;
        break;
      end
      if (reset_at >= 0 && got == reset_at) begin
        i_word_ready = 1'b0; i_block_valid = 1'b0;
        rst_n = 1'b0;
        #1 check("outs_in_reset", all_outs(), 0);
        @(posedge clk); #1;
        check("outs_in_reset_edge", all_outs(), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          check("no_done_after_reset", {o_done, o_busy}, 0);
        end
        return;
      end
      if (holding) check("hold_word", o_word, held);
      check("ready_valid_excl", o_block_ready & o_word_valid, 0);
      if (o_block_ready && req_checked != blk_idx) begin
        check("req_at_word", got, (blk_idx * IN_W) / n);
        req_checked = blk_idx;
      end
      if (o_block_ready && blk_idx >= nblk) begin
        check("extra_block_req", blk_idx, nblk - 1);
        break;
      end

      if (restart_at >= 0 && got == restart_at && !restarted) begin
        i_start     = 1'b1;
        i_nbits     = NB_W'((n % OUT_W) + 1 == n ? 3 : (n % OUT_W) + 1);
        i_num_words = 16'd5;
        restarted   = 1;
      end
      i_word_ready  = ($urandom_range(99) >= stall_pct);
      i_block_valid = (blk_idx < nblk) && ($urandom_range(99) >= stall_pct);
      i_block       = (blk_idx < nblk) ? blocks[blk_idx] : '0;

      holding = 0;
      if (o_word_valid && i_word_ready) begin
        check($sformatf("word%0d", got), o_word, exp_words[got]);
        got++;
        if (got == num) last_xfer = 1;
      end else if (o_word_valid) begin
        holding = 1;
        held    = o_word;
      end
      if (o_block_ready && i_block_valid) blk_idx++;
      @(posedge clk); #1;
    end
    i_word_ready = 1'b0; i_block_valid = 1'b0; i_start = 1'b0;
    if (!done_seen) check("run_timeout_words", got, num + 1);
    check("blocks_used", blk_idx, nblk);
    @(posedge clk); #1;
    check("idle_after_done", {o_done, o_busy, o_block_ready, o_word_valid}, 0);
  endtask

  // Empty run: one RUN cycle, then a done pulse, with no block request.
  task automatic run_empty();
    @(posedge clk); #1;
    i_nbits = NB_W'(7); i_num_words = 16'd0; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("empty_run_state", {o_busy, o_done, o_block_ready, o_word_valid}, 4'b1000);
    @(posedge clk); #1;
    check("empty_done", {o_done, o_block_ready}, 2'b10);
    @(posedge clk); #1;
    check("empty_idle", {o_done, o_busy}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    #1 check("outs_at_reset", all_outs(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("outs_after_release", all_outs(), 0);

    run_case(16, 84, 1, 0, -1, -1);
    run_case(15, 90, 1, 0, -1, -1);
    run_empty();
    run_case(0, 84, 1, 40, -1, -1);
    run_case(16, 84, 1, 0, 40, -1);
    run_case(16, 84, 1, 0, -1, -1);
    run_case(16, 84, 1, 0, -1, 20);
    run_case(13, 120, 0, 30, -1, 50);
    for (int r = 0; r < 6; r++) begin
      run_case($urandom_range(OUT_W), $urandom_range(300, 1), 1'b0,
               $urandom_range(60), -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
